// File: rtl/imm_encoder.sv
// imm_encoder: packs a 32-bit immediate into the inst[31:7] field for the I/S/B/U/J formats.
// Latency: 2 cycles (S1 request register, S2 encode/check register); throughput 1 per cycle.
// Backpressure: valid/ready. out_ready=0 holds S2, S1 fills behind it, then in_ready drops.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   in_valid/in_ready        request handshake; ExtenSel (format code) and imm_in (immediate)
//   out_valid/out_ready      result handshake; imm_out (imm_out[k] = inst[k+7]) and err
//   err_cnt, err_clr         saturating count of transferred err=1 results; synchronous clear
module imm_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ExtenSel,
  input  logic [31:0]      imm_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      imm_out,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] imm;
  } req_t;

  // S1: registered request
  logic  s1_valid;
  req_t  s1_req;

  // S2 load enable: output stage is empty or being drained this cycle
  logic  adv2;

  // Encoder results for the request sitting in S1
  logic [31:0] s1_imm;
  logic [24:0] enc_field;
  logic        enc_bad;

  // Sign-run checks: a range of upper bits that is all zeros or all ones
  logic        run_11_eq;   // imm[31:11], I/S range
  logic        run_12_eq;   // imm[31:12], B range
  logic        run_20_eq;   // imm[31:20], J range

  logic        cnt_hit;

  // ------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------
  assign adv2     = !out_valid || out_ready;
  // Gated by rst so upstream never sees a slot open while reset is held.
  assign in_ready = rst && (!s1_valid || adv2);

  // ------------------------------------------------------------------
  // S1: request register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
    end else if (in_ready) begin
      // in_ready implies S1 is empty or moving into S2 this edge.
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_req.sel <= ExtenSel;
        s1_req.imm <= imm_in;
      end
    end
  end

  // ------------------------------------------------------------------
  // Encode and representability check (combinational on S1)
  // ------------------------------------------------------------------
  assign s1_imm    = s1_req.imm;
  assign run_11_eq = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
  assign run_12_eq = (&s1_imm[31:12]) || !(|s1_imm[31:12]);
  assign run_20_eq = (&s1_imm[31:20]) || !(|s1_imm[31:20]);

  always_comb begin
    enc_field = '0;
    enc_bad   = 1'b0;
    case (s1_req.sel)
      FMT_I: begin
        enc_bad          = !run_11_eq;
        enc_field[24:13] = s1_imm[11:0];
      end
      FMT_S: begin
        enc_bad          = !run_11_eq;
        enc_field[24:18] = s1_imm[11:5];
        enc_field[4:0]   = s1_imm[4:0];
      end
      FMT_B: begin
        // Byte offset must be halfword aligned; bit 0 is not encoded.
        enc_bad          = !run_12_eq || s1_imm[0];
        enc_field[24]    = s1_imm[12];
        enc_field[23:18] = s1_imm[10:5];
        enc_field[4:1]   = s1_imm[4:1];
        enc_field[0]     = s1_imm[11];
      end
      FMT_U: begin
        enc_bad          = |s1_imm[11:0];
        enc_field[24:5]  = s1_imm[31:12];
      end
      FMT_J: begin
        enc_bad          = !run_20_eq || s1_imm[0];
        enc_field[24]    = s1_imm[20];
        enc_field[23:14] = s1_imm[10:1];
        enc_field[13]    = s1_imm[11];
        enc_field[12:5]  = s1_imm[19:12];
      end
      default: begin
        enc_bad = 1'b1;
      end
    endcase
    // A failed check yields an all-zero field rather than a truncated value.
    if (enc_bad) begin
      enc_field = '0;
    end
  end

  // ------------------------------------------------------------------
  // S2: output register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      imm_out   <= '0;
      err       <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      // Data only moves with a real request so a bubble leaves the last result untouched.
      if (s1_valid) begin
        imm_out <= enc_field;
        err     <= enc_bad;
      end
    end
  end

  // ------------------------------------------------------------------
  // Error counter: counts transferred err=1 results; clear wins over increment
  // ------------------------------------------------------------------
  assign cnt_hit = out_valid && out_ready && err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (cnt_hit && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: randomized and directed bench for imm_encoder with an in-bench reference model.
// Expected results come from a format-range model and a SignExten decoder applied to imm_out.
// A negedge monitor tracks accepted requests in a queue and checks every result transfer.
module tb_imm_encoder;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       ExtenSel = 3'b000;
  logic [31:0]      imm_in = 32'h0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [24:0]      imm_out;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic             err_clr = 1'b0;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ExtenSel  (ExtenSel),
    .imm_in    (imm_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_out   (imm_out),
    .err       (err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] imm;
    int          cyc;
    bit          has_exp;
    logic [24:0] exp_out;
  } txn_t;

  txn_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          exp_cnt = 0;
  int          n_err = 0;
  int          rdy_den = 2;
  bit          lat_chk = 1'b0;
  bit          rnd_rdy = 1'b0;
  bit          held_v = 1'b0;
  logic [24:0] held_out;
  logic        held_err;
  bit          drv_has_exp = 1'b0;
  logic [24:0] drv_exp_out = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference SignExten: rebuilds the immediate from inst = {imm_out, 7'b0}.
  function automatic logic [31:0] sign_exten(input logic [2:0] sel, input logic [24:0] f);
    logic [31:0] inst;
    inst = {f, 7'b0};
    case (sel)
      3'd0:    return {{20{inst[31]}}, inst[31:20]};
      3'd1:    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
      3'd2:    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      3'd3:    return {inst[31:12], 12'h000};
      3'd4:    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // Representability as plain signed ranges and alignment.
  function automatic bit model_err(input logic [2:0] sel, input logic [31:0] imm);
    longint s;
    s = longint'($signed(imm));
    case (sel)
      3'd0, 3'd1: return !(s >= -2048 && s <= 2047);
      3'd2:       return !(s >= -4096 && s <= 4095 && (imm % 2) == 0);
      3'd3:       return (imm % 4096) != 0;
      3'd4:       return !(s >= -(64'sd1 <<< 20) && s < (64'sd1 <<< 20) && (imm % 2) == 0);
      default:    return 1'b1;
    endcase
  endfunction

  // Field bits each format is allowed to drive.
  function automatic logic [24:0] used_mask(input logic [2:0] sel);
    case (sel)
      3'd0:       return 25'h1FFE000;
      3'd1, 3'd2: return 25'h1FC001F;
      3'd3, 3'd4: return 25'h1FFFFE0;
      default:    return 25'h0;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Random out_ready, updated after the main process has driven its inputs.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_rdy) out_ready = ($urandom_range(0, rdy_den - 1) != 0);
    end
  end

  // Monitor: sampled at negedge, models the transfers that happen at the next posedge.
  always @(negedge clk) begin
    txn_t t;
    bit   e;
    bit   cnt_inc;
    cnt_inc = 1'b0;
    chk("in_ready", in_ready, (rst && (exp_q.size() < 2 || out_ready)));
    chk("err_cnt", err_cnt, exp_cnt);
    if (!rst) begin
      exp_q.delete();
      held_v  = 1'b0;
      exp_cnt = 0;
    end else begin
      if (held_v) begin
        chk("hold_vld", out_valid, 1);
        chk("hold_out", imm_out, held_out);
        chk("hold_err", err, held_err);
      end
      held_v   = out_valid && !out_ready;
      held_out = imm_out;
      held_err = err;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious", out_valid, 0);
        end else begin
          t = exp_q.pop_front();
          e = model_err(t.sel, t.imm);
          chk("err", err, e);
          if (e) begin
            chk("err_zero", imm_out, 0);
            n_err++;
            cnt_inc = 1'b1;
          end else begin
            chk("roundtrip", sign_exten(t.sel, imm_out), t.imm);
            chk("unused", imm_out & ~used_mask(t.sel), 0);
          end
          if (t.has_exp) chk("enc", imm_out, t.exp_out);
          if (lat_chk) chk("latency", cyc - t.cyc, 2);
        end
      end
      if (err_clr) exp_cnt = 0;
      else if (cnt_inc && exp_cnt < 255) exp_cnt++;
      if (in_valid && in_ready)
        exp_q.push_back('{ExtenSel, imm_in, cyc, drv_has_exp, drv_exp_out});
    end
  end

  // Called just after a posedge; returns just after the edge that accepted the request.
  task automatic send(input logic [2:0] sel, input logic [31:0] imm,
                      input bit has_exp, input logic [24:0] exp_out);
    bit acc;
    acc         = 1'b0;
    ExtenSel    = sel;
    imm_in      = imm;
    drv_has_exp = has_exp;
    drv_exp_out = exp_out;
    in_valid    = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid    = 1'b0;
    drv_has_exp = 1'b0;
    if (!acc) chk("send_timeout", acc, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [2:0]  enc_sel [5] = '{3'd0, 3'd0, 3'd3, 3'd4, 3'd1};
  logic [31:0] enc_imm [5] = '{32'h00000001, 32'hFFFFFFFF, 32'h12345000, 32'h00000002, 32'hFFFFFFE1};
  logic [24:0] enc_exp [5] = '{25'h0002000, 25'h1FFE000, 25'h02468A0, 25'h0004000, 25'h1FC0001};

  initial begin
    logic [2:0]  rs;
    logic [31:0] ri;
    logic [31:0] tmp;

    // Reset held for 3 edges with a request pending
    rst      = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_imm_out", imm_out, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Directed encodings, back-to-back, out_ready held high
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    for (int i = 0; i < 5; i++) send(enc_sel[i], enc_imm[i], 1'b1, enc_exp[i]);
    drain();

    // Error results still transfer and are counted
    send(3'd0, 32'h00000800, 1'b0, '0);
    send(3'd2, 32'h00000003, 1'b0, '0);
    send(3'd7, 32'h00001234, 1'b0, '0);
    drain();
    chk("err_cnt_3", err_cnt, 3);

    // Clear coincides with the transfer of another error result: clear wins
    send(3'd6, 32'h0, 1'b0, '0);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    drain();
    chk("err_clr", err_cnt, 0);

    // Backpressure: 6 I-type requests with random out_ready
    lat_chk = 1'b0;
    rdy_den = 2;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 6; i++) send(3'd0, i, 1'b0, '0);
    rnd_rdy   = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset while two entries are stalled
    out_ready = 1'b0;
    send(3'd0, 32'h10, 1'b0, '0);
    send(3'd0, 32'h11, 1'b0, '0);
    @(posedge clk);
    #1;
    chk("stall_in_ready", in_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    rst       = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("no_stale", out_valid, 0);
    end

    // Random round trip
    n_err   = 0;
    rdy_den = 4;
    rnd_rdy = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      rs  = 3'($urandom_range(0, 7));
      tmp = $urandom;
      case ($urandom_range(0, 3))
        0:       ri = tmp;
        1:       ri = {{19{tmp[12]}}, tmp[12:0]};
        2:       ri = {{11{tmp[20]}}, tmp[20:1], 1'b0};
        default: ri = tmp & 32'hFFFFF000;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(rs, ri, 1'b0, '0);
    end
    rnd_rdy   = 1'b0;
    out_ready = 1'b1;
    drain();
    @(posedge clk);
    #1;
    chk("sat_cnt", err_cnt, (n_err >= 255) ? 255 : n_err);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
